// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU and load results onto the register-file write port,
// extends load data, flags bad loads and counts retired results.
module writeback_stage #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic [2:0]        lsu_funct3,
    input  logic [1:0]        lsu_addr_lo,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_reg_c,
    output logic [DATA_W-1:0] rf_data_c,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_fault,
    output logic [CNT_W-1:0]  retire_count
);

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    function automatic logic signed [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        funct3,
        input logic [1:0]        lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F_LB:    load_extract = {{(DATA_W-8){b[7]}}, b};
            F_LBU:   load_extract = {{(DATA_W-8){1'b0}}, b};
            F_LH:    load_extract = {{(DATA_W-16){h[15]}}, h};
            F_LHU:   load_extract = {{(DATA_W-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3)
            F_LB, F_LBU: load_bad = 1'b0;
            F_LH, F_LHU: load_bad = lo[0];
            F_LW:        load_bad = (lo != 2'd0);
            default:     load_bad = 1'b1;
        endcase
    endfunction

    logic                     ptr_lsu;
    logic                     both_p0;
    logic                     alu_gnt_p0;
    logic                     lsu_gnt_p0;
    logic                     vld_p0;
    logic                     flt_p0;
    logic [ADDR_W-1:0]        rd_p0;
    logic signed [DATA_W-1:0] data_p0;

    // Stage p0: arbitration and load extraction (combinational)
    always_comb begin
        both_p0    = alu_valid && lsu_valid;
        lsu_gnt_p0 = rst_n && en && lsu_valid && (!alu_valid || ptr_lsu);
        alu_gnt_p0 = rst_n && en && alu_valid && (!lsu_valid || !ptr_lsu);
        vld_p0     = alu_gnt_p0 || lsu_gnt_p0;
        flt_p0     = lsu_gnt_p0 && load_bad(lsu_funct3, lsu_addr_lo);
        rd_p0      = lsu_gnt_p0 ? lsu_rd : alu_rd;
        data_p0    = lsu_gnt_p0 ? load_extract(lsu_data, lsu_funct3, lsu_addr_lo)
                                : $signed(alu_data);
    end

    assign alu_ready = alu_gnt_p0;
    assign lsu_ready = lsu_gnt_p0;

    // Stage p1: registered write port, fault pulse, retire counter, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_reg_c     <= '0;
            rf_data_c    <= '0;
            load_fault   <= 1'b0;
            retire_count <= '0;
            ptr_lsu      <= 1'b1;
        end else begin
            rf_we      <= vld_p0 && (rd_p0 != '0) && !flt_p0;
            load_fault <= flt_p0;
            if (vld_p0) begin
                rf_reg_c     <= rd_p0;
                rf_data_c    <= data_p0;
                retire_count <= retire_count + CNT_W'(1);
            end
            if (en && both_p0) begin
                ptr_lsu <= !ptr_lsu;
            end
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_reg_c;
    assign fwd_data  = rf_data_c;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        alu_valid, lsu_valid;
    logic [5:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lo;

    logic        alu_ready, lsu_ready, rf_we, fwd_valid, load_fault;
    logic [5:0]  rf_reg_c, fwd_rd;
    logic [31:0] rf_data_c, fwd_data, retire_count;

    logic        u4_alu_ready, u4_lsu_ready, u4_rf_we, u4_fwd_valid, u4_load_fault;
    logic [5:0]  u4_rf_reg_c, u4_fwd_rd;
    logic [31:0] u4_rf_data_c, u4_fwd_data;
    logic [3:0]  u4_retire_count;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
        .rf_we(rf_we), .rf_reg_c(rf_reg_c), .rf_data_c(rf_data_c),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_fault(load_fault), .retire_count(retire_count)
    );

    writeback_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .alu_valid(alu_valid), .alu_ready(u4_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(u4_lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
        .rf_we(u4_rf_we), .rf_reg_c(u4_rf_reg_c), .rf_data_c(u4_rf_data_c),
        .fwd_valid(u4_fwd_valid), .fwd_rd(u4_fwd_rd), .fwd_data(u4_fwd_data),
        .load_fault(u4_load_fault), .retire_count(u4_retire_count)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic        m_ptr_lsu;
    logic        m_we, m_flt, m_dknown;
    logic [5:0]  m_rd;
    logic [31:0] m_data;
    int unsigned m_cnt;

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
        int v;
        case (f3)
            3'b000, 3'b100: begin
                v = int'((w >> (8 * lo)) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = int'((w >> (16 * lo[1])) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    function automatic logic mdl_fault(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (lo % 2) != 0;
        if (f3 == 3'b010) return lo != 0;
        return 1'b1;
    endfunction

    function automatic logic mdl_legal(input logic [2:0] f3);
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    task automatic mdl_reset();
        m_ptr_lsu = 1'b1; m_we = 0; m_flt = 0; m_rd = 0; m_data = 0; m_dknown = 1; m_cnt = 0;
    endtask

    task automatic chk_outputs();
        chk("rf_we", rf_we, m_we);
        chk("rf_reg_c", rf_reg_c, m_rd);
        if (m_dknown) chk("rf_data_c", rf_data_c, m_data);
        chk("load_fault", load_fault, m_flt);
        chk("retire_count", retire_count, m_cnt);
        chk("retire_count_w4", u4_retire_count, m_cnt % 16);
        chk("fwd_valid", fwd_valid, m_we);
        chk("fwd_rd", fwd_rd, m_rd);
        if (m_dknown) chk("fwd_data", fwd_data, m_data);
    endtask

    // One clock with inputs already driven: checks readies, clocks, checks registers.
    task automatic mcycle();
        logic ga, gl, flt;
        ga = 0; gl = 0;
        #1;
        if (en) begin
            if (alu_valid && lsu_valid) begin
                gl = m_ptr_lsu; ga = !m_ptr_lsu;
            end else begin
                ga = alu_valid; gl = lsu_valid;
            end
        end
        chk("alu_ready", alu_ready, ga);
        chk("lsu_ready", lsu_ready, gl);
        @(posedge clk);
        if (ga || gl) begin
            flt = gl && mdl_fault(lsu_funct3, lsu_addr_lo);
            m_cnt++;
            m_rd = gl ? lsu_rd : alu_rd;
            m_data = gl ? mdl_load(lsu_data, lsu_funct3, lsu_addr_lo) : alu_data;
            m_dknown = !gl || mdl_legal(lsu_funct3);
            m_we = (m_rd != 0) && !flt;
            m_flt = flt;
        end else begin
            m_we = 0; m_flt = 0;
        end
        if (en && alu_valid && lsu_valid) m_ptr_lsu = !m_ptr_lsu;
        #1;
        chk_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 1; alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0;
        alu_data = 0; lsu_data = 0; lsu_funct3 = 0; lsu_addr_lo = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 1; alu_valid = 1; lsu_valid = 1;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_reg_c", rf_reg_c, 0);
        chk("rst_rf_data_c", rf_data_c, 0);
        chk("rst_load_fault", load_fault, 0);
        chk("rst_retire_count", retire_count, 0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        mdl_reset();
    endtask

    typedef struct {
        logic        av;
        logic [5:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [5:0]  lrd;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        ar, lr, we;
        logic [5:0]  rd;
        logic [31:0] dat;
        logic        flt;
        int          cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 3'd0, 2'd0, 1, 0, 1, 5, 32'hDEADBEEF, 0, 1};
        tbl[1] = '{0, 0, 32'h0, 1, 1, 3'd0, 2'd3, 0, 1, 1, 1, 32'hFFFFFF80, 0, 2};
        tbl[2] = '{0, 0, 32'h0, 1, 2, 3'd4, 2'd2, 0, 1, 1, 2, 32'h000000FF, 0, 3};
        tbl[3] = '{0, 0, 32'h0, 1, 3, 3'd1, 2'd2, 0, 1, 1, 3, 32'hFFFF80FF, 0, 4};
        tbl[4] = '{0, 0, 32'h0, 1, 4, 3'd5, 2'd0, 0, 1, 1, 4, 32'h00007F01, 0, 5};
        tbl[5] = '{0, 0, 32'h0, 1, 6, 3'd2, 2'd1, 0, 1, 0, 6, 32'h80FF7F01, 1, 6};
        tbl[6] = '{1, 0, 32'h1234, 0, 0, 3'd0, 2'd0, 1, 0, 0, 0, 32'h00001234, 0, 7};
        tbl[7] = '{0, 0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h00001234, 0, 7};
        tbl[8] = '{0, 0, 32'h0, 1, 7, 3'd2, 2'd0, 0, 1, 1, 7, 32'h80FF7F01, 0, 8};

        idle_inputs();
        do_reset();

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = 32'h80FF7F01;
            lsu_funct3 = tbl[i].f3; lsu_addr_lo = tbl[i].lo;
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].ar);
            chk($sformatf("v%0d_lsu_ready", i), lsu_ready, tbl[i].lr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].we);
            chk($sformatf("v%0d_rf_reg_c", i), rf_reg_c, tbl[i].rd);
            chk($sformatf("v%0d_rf_data_c", i), rf_data_c, tbl[i].dat);
            chk($sformatf("v%0d_load_fault", i), load_fault, tbl[i].flt);
            chk($sformatf("v%0d_retire_count", i), retire_count, tbl[i].cnt);
            @(negedge clk);
        end

        // Both valid for four cycles: grants alternate starting with LSU
        do_reset();
        alu_valid = 1; alu_rd = 10; alu_data = 32'hAAAA0000;
        lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h5555FFFF; lsu_funct3 = 3'b010; lsu_addr_lo = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_lsu_ready", i), lsu_ready, (i % 2) == 0);
            chk($sformatf("rr%0d_alu_ready", i), alu_ready, (i % 2) == 1);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_rf_reg_c", i), rf_reg_c, ((i % 2) == 0) ? 20 : 10);
            @(negedge clk);
        end
        chk("rr_retire_count", retire_count, 4);
        m_ptr_lsu = 1'b1; m_cnt = 4; m_we = 1; m_rd = 10; m_data = 32'hAAAA0000; m_flt = 0;

        // Enable low with both sources offering: nothing moves
        en = 0;
        for (int i = 0; i < 3; i++) mcycle();
        chk("en0_retire_count", retire_count, 4);
        en = 1;
        mcycle();
        chk("en1_lsu_first", rf_reg_c, 20);

        // Asynchronous reset right after an accept
        alu_valid = 1; lsu_valid = 0; alu_rd = 9; alu_data = 32'h55;
        @(posedge clk);
        #2;
        chk("pre_rst_rf_we", rf_we, 1);
        rst_n = 0;
        #1;
        chk("async_rf_we", rf_we, 0);
        chk("async_retire_count", retire_count, 0);
        chk("async_rf_reg_c", rf_reg_c, 0);
        chk("async_alu_ready", alu_ready, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        mdl_reset();

        // Counter wrap in the 4-bit instance
        alu_valid = 1; alu_rd = 3; alu_data = 32'h77;
        for (int i = 0; i < 17; i++) mcycle();
        chk("wrap_w4", u4_retire_count, 1);
        chk("wrap_w32", retire_count, 17);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en          = ($urandom_range(0, 7) != 0);
            alu_valid   = $urandom_range(0, 1);
            lsu_valid   = $urandom_range(0, 1);
            alu_rd      = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
            lsu_rd      = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
            alu_data    = $urandom;
            lsu_data    = $urandom;
            lsu_funct3  = 3'($urandom);
            lsu_addr_lo = 2'($urandom);
            mcycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
